// File: rtl/neander_mem_arbiter.sv
// rtl/neander_mem_arbiter.sv - round-robin arbiter sharing one single-port RAM between CPU and debug
//
// Purpose: serialises CPU (port 0) and debug/loader (port 1) accesses onto one
// RAM. Each access is a fixed-latency transaction: the grant latches the
// winner's request, the RAM is driven for MEM_LAT cycles, and the owner then
// gets a one-cycle ack.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_rdata, cpu_ack   CPU request port
//   dbg_req/we/addr/wdata -> dbg_rdata, dbg_ack   debug/loader request port
//   mem_en/we/addr/wdata, mem_rdata     RAM macro interface
//   busy                                high whenever a transaction is in flight
//   owner                               port of the current or last transaction
module neander_mem_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // The counter counts down the remaining ACCESS cycles after the first one.
   localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

   state_t            state;
   state_t            state_next;
   logic [3:0]        cnt;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              owner_q;
   logic              last_grant;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dbg_rdata_q;
   logic              grant;
   logic              grant_port;

   always_comb begin
      state_next = state;
      grant      = 1'b0;
      grant_port = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      cpu_ack    = 1'b0;
      dbg_ack    = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req && dbg_req) begin
               // Tie: the port that did not win last time goes next.
               grant      = 1'b1;
               grant_port = ~last_grant;
            end else if (cpu_req) begin
               grant      = 1'b1;
               grant_port = 1'b0;
            end else if (dbg_req) begin
               grant      = 1'b1;
               grant_port = 1'b1;
            end
            if (grant) begin
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            mem_en = 1'b1;
            mem_we = we_q;
            if (cnt == 4'd0) begin
               state_next = RESP;
            end
         end
         RESP: begin
            cpu_ack    = ~owner_q;
            dbg_ack    = owner_q;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= 4'd0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         owner_q     <= 1'b1;
         last_grant  <= 1'b1;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  owner_q <= grant_port;
                  cnt     <= CNT_LOAD;
                  if (grant_port) begin
                     we_q    <= dbg_we;
                     addr_q  <= dbg_addr;
                     wdata_q <= dbg_wdata;
                  end else begin
                     we_q    <= cpu_we;
                     addr_q  <= cpu_addr;
                     wdata_q <= cpu_wdata;
                  end
               end
            end
            ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else if (!we_q) begin
                  // Last ACCESS cycle: RAM output has been stable for MEM_LAT cycles.
                  if (owner_q) begin
                     dbg_rdata_q <= mem_rdata;
                  end else begin
                     cpu_rdata_q <= mem_rdata;
                  end
               end
            end
            RESP: begin
               last_grant <= owner_q;
            end
            default: begin
            end
         endcase
      end
   end

   // Address and data come straight from the latched request so the RAM sees
   // stable inputs for the whole access, whatever the requesters do meanwhile.
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign busy      = (state != IDLE);
   assign owner     = owner_q;

endmodule

// File: tb/tb_neander_mem_arbiter.sv
// tb/tb_neander_mem_arbiter.sv - scoreboard testbench for neander_mem_arbiter
module tb_neander_mem_arbiter;

   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 8;
   localparam int MEM_LAT = 2;
   localparam int TXN_CYC = MEM_LAT + 2;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic       cpu_req   = 1'b0;
   logic       cpu_we    = 1'b0;
   logic [7:0] cpu_addr  = 8'h00;
   logic [7:0] cpu_wdata = 8'h00;
   logic [7:0] cpu_rdata;
   logic       cpu_ack;
   logic       dbg_req   = 1'b0;
   logic       dbg_we    = 1'b0;
   logic [7:0] dbg_addr  = 8'h00;
   logic [7:0] dbg_wdata = 8'h00;
   logic [7:0] dbg_rdata;
   logic       dbg_ack;
   logic       mem_en;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       busy;
   logic       owner;

   always #5 clk = ~clk;

   neander_mem_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .MEM_LAT(MEM_LAT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata),
      .cpu_ack  (cpu_ack),
      .dbg_req  (dbg_req),
      .dbg_we   (dbg_we),
      .dbg_addr (dbg_addr),
      .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata),
      .dbg_ack  (dbg_ack),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .busy     (busy),
      .owner    (owner)
   );

   function automatic logic [7:0] mem_init(input int a);
      if (a == 'h10) return 8'h5A;
      if (a == 'h11) return 8'h77;
      return 8'(a * 37 + 5);
   endfunction

   // RAM model: read data is only valid once address and enable have been
   // stable for MEM_LAT cycles; before that it returns garbage.
   logic [7:0] ram [256];
   logic       ram_ready   = 1'b0;
   int         stable_cnt  = 0;
   logic [7:0] stable_addr = 8'h00;
   int         we_cycles   = 0;

   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 256; i++) ram[i] <= mem_init(i);
         ram_ready <= 1'b1;
      end else if (mem_en && mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
      if (mem_en) begin
         if (stable_cnt != 0 && mem_addr == stable_addr) begin
            stable_cnt <= stable_cnt + 1;
         end else begin
            stable_cnt  <= 1;
            stable_addr <= mem_addr;
         end
      end else begin
         stable_cnt <= 0;
      end
      if (mem_en && mem_we) we_cycles <= we_cycles + 1;
   end

   assign mem_rdata = (mem_en && stable_cnt >= MEM_LAT - 1) ? ram[mem_addr] : 8'hEE;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard state
   logic [7:0] ref_mem [256];
   logic [7:0] model_rdata [2];
   logic [7:0] exp_q0 [$];
   logic [7:0] exp_q1 [$];
   int         ack_port_log [$];
   int         ack_cyc_log [$];
   int         ack_cnt [2];
   int         n_checks = 0;
   int         n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the expected response whenever an ack appears.
   always @(negedge clk) begin
      if (cpu_ack || dbg_ack) check("ack_exclusive", 32'(cpu_ack & dbg_ack), 0);
      if (cpu_ack) begin
         ack_cnt[0]++;
         ack_port_log.push_back(0);
         ack_cyc_log.push_back(cyc);
         if (exp_q0.size() == 0) check("cpu_ack_unexpected", 32'(cpu_ack), 0);
         else check("cpu_rdata", 32'(cpu_rdata), 32'(exp_q0.pop_front()));
      end
      if (dbg_ack) begin
         ack_cnt[1]++;
         ack_port_log.push_back(1);
         ack_cyc_log.push_back(cyc);
         if (exp_q1.size() == 0) check("dbg_ack_unexpected", 32'(dbg_ack), 0);
         else check("dbg_rdata", 32'(dbg_rdata), 32'(exp_q1.pop_front()));
      end
   end

   // Reference model: a read returns the memory word, a write updates memory
   // and leaves the port's read register as it was.
   task automatic issue(input int port, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
      logic [7:0] e;
      if (we) begin
         ref_mem[addr] = wdata;
         e = model_rdata[port];
      end else begin
         e = ref_mem[addr];
         model_rdata[port] = e;
      end
      if (port == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
   endtask

   task automatic do_txn(input int port, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, output int lat);
      bit got;
      got = 1'b0;
      issue(port, we, addr, wdata);
      if (port == 0) begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end else begin
         dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      end
      lat = 0;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         lat++;
         if ((port == 0 && cpu_ack) || (port == 1 && dbg_ack)) got = 1'b1;
      end
      check(port == 0 ? "cpu_ack_seen" : "dbg_ack_seen", 32'(got), 1);
      @(posedge clk);
      #1;
      if (port == 0) cpu_req = 1'b0;
      else dbg_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int saved;
      for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);
      model_rdata[0] = 8'h00;
      model_rdata[1] = 8'h00;
      ack_cnt[0] = 0;
      ack_cnt[1] = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_owner", 32'(owner), 1);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
      check("rst_cpu_rdata", 32'(cpu_rdata), 0);
      check("rst_dbg_rdata", 32'(dbg_rdata), 0);
      check("rst_acks", 32'({cpu_ack, dbg_ack}), 0);

      // CPU read of 0x10, cycle-exact
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
      issue(0, 1'b0, 8'h10, 8'h00);
      @(negedge clk);
      check("t1_c0_busy", 32'(busy), 0);
      @(negedge clk);
      check("t1_c1_en", 32'(mem_en), 1);
      check("t1_c1_addr", 32'(mem_addr), 'h10);
      @(negedge clk);
      check("t1_c2_en", 32'(mem_en), 1);
      check("t1_c2_addr", 32'(mem_addr), 'h10);
      @(negedge clk);
      check("t1_c3_ack", 32'(cpu_ack), 1);
      check("t1_c3_en", 32'(mem_en), 0);
      cpu_req = 1'b0;
      @(negedge clk);
      check("t1_c4_busy", 32'(busy), 0);

      // Address change and req drop in the first ACCESS cycle
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
      issue(0, 1'b0, 8'h10, 8'h00);
      @(negedge clk);
      @(negedge clk);
      check("t4_c1_addr", 32'(mem_addr), 'h10);
      cpu_addr = 8'h11;
      cpu_req  = 1'b0;
      @(negedge clk);
      check("t4_c2_addr", 32'(mem_addr), 'h10);
      @(negedge clk);
      check("t5_ack", 32'(cpu_ack), 1);
      @(negedge clk);
      check("t5_ack_once", 32'(cpu_ack), 0);
      check("t5_idle", 32'(busy), 0);

      // Debug write then CPU read of the same address
      @(posedge clk); #1;
      saved = we_cycles;
      do_txn(1, 1'b1, 8'h20, 8'hC3, lat);
      check("t2_dbg_lat", 32'(lat), TXN_CYC);
      check("t2_we_cycles", 32'(we_cycles - saved), MEM_LAT);
      check("t2_ram", 32'(ram[8'h20]), 'hC3);
      do_txn(0, 1'b0, 8'h20, 8'h00, lat);
      check("t2_cpu_lat", 32'(lat), TXN_CYC);

      // Reset in the second ACCESS cycle of a debug write
      saved = ack_cnt[1];
      @(posedge clk); #1;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h30; dbg_wdata = 8'h99;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("t6_c2_en", 32'(mem_en), 1);
      reset = 1'b1;
      dbg_req = 1'b0;
      @(negedge clk);
      check("t6_en_after_rst", 32'(mem_en), 0);
      check("t6_idle_after_rst", 32'(busy), 0);
      check("t6_no_ack", 32'(dbg_ack), 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("t6_no_ack_later", 32'(ack_cnt[1] - saved), 0);
      ref_mem[8'h30] = 8'h99;
      model_rdata[0] = 8'h00;
      model_rdata[1] = 8'h00;

      // Simultaneous requests held continuously: CPU first, then alternate
      ack_port_log.delete();
      ack_cyc_log.delete();
      @(posedge clk); #1;
      fork
         begin
            int lc;
            for (int k = 0; k < 2; k++) do_txn(0, 1'b0, 8'(8'h10 + k), 8'h00, lc);
         end
         begin
            int ld;
            for (int k = 0; k < 2; k++) do_txn(1, 1'b1, 8'(8'h40 + k), 8'(8'hA0 + k), ld);
         end
      join
      check("t3_ack_count", 32'(ack_port_log.size()), 4);
      for (int i = 0; i < 4 && i < ack_port_log.size(); i++)
         check("t3_grant_order", 32'(ack_port_log[i]), 32'(i % 2));
      for (int i = 1; i < 4 && i < ack_cyc_log.size(); i++)
         check("t3_ack_spacing", 32'(ack_cyc_log[i] - ack_cyc_log[i-1]), TXN_CYC);

      // Randomised traffic; each port owns half of the address space
      fork
         begin
            int g; int l; logic w; logic [7:0] a; logic [7:0] d;
            for (int k = 0; k < 30; k++) begin
               g = $urandom_range(0, 3);
               repeat (g) @(posedge clk);
               #1;
               w = 1'($urandom_range(0, 1));
               a = 8'($urandom_range(0, 127));
               d = 8'($urandom);
               do_txn(0, w, a, d, l);
               check("rnd_cpu_lat", 32'(l >= TXN_CYC && l <= 2 * TXN_CYC), 1);
            end
         end
         begin
            int g; int l; logic w; logic [7:0] a; logic [7:0] d;
            for (int k = 0; k < 30; k++) begin
               g = $urandom_range(0, 3);
               repeat (g) @(posedge clk);
               #1;
               w = 1'($urandom_range(0, 1));
               a = 8'(8'h80 | 8'($urandom_range(0, 127)));
               d = 8'($urandom);
               do_txn(1, w, a, d, l);
               check("rnd_dbg_lat", 32'(l >= TXN_CYC && l <= 2 * TXN_CYC), 1);
            end
         end
      join

      repeat (4) @(negedge clk);
      check("cpu_queue_empty", 32'(exp_q0.size()), 0);
      check("dbg_queue_empty", 32'(exp_q1.size()), 0);
      for (int i = 0; i < 256; i++) check("ram_contents", 32'(ram[i]), 32'(ref_mem[i]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
